addr_gen_hc_multi: RTL and testbench
====================================

Name: addr_gen_hc_multi

Overview:
Parametrised read-address generator for the LSTM recurrent state memories H and C, used in forward propagation and reusable for BPTT via reverse timestep order.
For every timestep and every group of NUM_LANE cells it does three things in order:
- streams the NUM_CELL previous-h addresses,
- idles DELAY cycles for the MAC pipeline,
- issues NUM_LANE parallel c addresses.

It adds a start/busy/done handshake, multi-lane C reads and direction mode. Memory slot t holds h(t-1)/c(t-1); slot 0 is the zero state.

Parameters:
- ADDR_WIDTH, 12, address width; (TIMESTEP+1)*NUM_CELL <= 2^ADDR_WIDTH required.
- TIMESTEP, 7, number of timesteps processed per run.
- NUM_CELL, 8, LSTM cells per layer; length of each h stream.
- NUM_LANE, 2, parallel cell lanes; NUM_CELL % NUM_LANE == 0 required.
- DELAY, 48, idle cycles between end of h stream and c read; 0 allowed.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  advance enable; low freezes all state and outputs.
- i_start  in  1  run request, sampled only in IDLE with i_en=1.
- i_dir  in  1  0 = forward (t ascending), 1 = backward (t descending); latched at start.
- o_busy  out  1  high from accepted start until DONE exits.
- o_done  out  1  one-cycle pulse after the last c read.
- o_valid_h  out  1  o_addr_h valid this cycle.
- o_addr_h  out  ADDR_WIDTH  h read address.
- o_valid_c  out  1  o_addr_c valid this cycle.
- o_addr_c  out  NUM_LANE*ADDR_WIDTH  packed c addresses; lane l in bits [l*ADDR_WIDTH +: ADDR_WIDTH].

Behaviour:
- Reset:
  - State IDLE.
  - All outputs, addresses and counters are 0.
  - Reset takes priority over i_en and aborts a run mid-operation; no o_done is produced.
- All outputs are registered; there is no combinational input-to-output path.
- With i_en=0, state, counters and outputs hold; a stalled valid stays high. The consumer shares i_en.
- Counters: k (0..NUM_CELL-1), w (0..DELAY-1), g (0..NUM_CELL/NUM_LANE-1), t (0..TIMESTEP-1).
  - First t is 0 when forward, TIMESTEP-1 when backward.
  - Last t is TIMESTEP-1 when forward, 0 when backward.
- IDLE:
  - On i_start, latch i_dir, set g=0 and t=first, then enter STREAM_H.
  - On the same edge, o_addr_h <= t*NUM_CELL, o_valid_h <= 1, o_busy <= 1.
  - Latency from start to first address is 1 cycle.
- STREAM_H:
  - o_addr_h = t*NUM_CELL + k.
  - At k==NUM_CELL-1, go to WAIT, or directly to READ_C if DELAY==0.
- WAIT:
  - o_valid_h=0, o_valid_c=0.
  - Leave to READ_C when w==DELAY-1.
- READ_C:
  - One cycle with o_valid_c=1; lane l = t*NUM_CELL + g*NUM_LANE + l.
  - If g is not the last group: g++ and return to STREAM_H.
  - Else if t is not the last timestep: g=0, step t, return to STREAM_H.
  - Else go to DONE.
- DONE:
  - One cycle with o_done=1 and o_busy=0 on exit, then IDLE.
  - i_start in DONE is ignored.
- i_start while busy is ignored; no queuing.
- Addresses hold their last driven value while their valid is low.
- Cycles per group = NUM_CELL+DELAY+1.
- A run takes TIMESTEP*(NUM_CELL/NUM_LANE)*(NUM_CELL+DELAY+1) cycles, plus 1 DONE cycle.
- Arithmetic is unsigned at ADDR_WIDTH. The legal parameter check guarantees no wrap.
- Address generation never touches the final slot TIMESTEP*NUM_CELL.. (the write-only h(T-1)/c(T-1) slot).

Test Plan:
All scenarios use TIMESTEP=2, NUM_CELL=4, NUM_LANE=2, DELAY=3, i_en=1 unless stated; the start pulse is sampled at edge 0.
- Forward run:
  - o_valid_h in cycles 1-4 with addr 0,1,2,3.
  - Idle cycles 5-7.
  - Cycle 8: o_valid_c, lanes {0,1}.
  - Cycles 9-12: h 0..3; cycle 16: c {2,3}.
  - Cycles 17-20: h 4..7; cycle 24: c {4,5}.
  - Cycle 32: c {6,7}.
  - Cycle 33: o_done=1; o_busy low from cycle 34.
- Backward run (i_dir=1):
  - Cycles 1-4: h 4..7; cycle 8: c {4,5}.
  - Last c {2,3} at cycle 32; done at 33.
- Stall: drop i_en for cycles 3-5.
  - o_addr_h holds 2 with valid high.
  - The stream resumes 3,... and the whole schedule shifts by 3; done at 36.
- Start during busy and in DONE ignored.
  - A start at cycle 10 changes nothing.
  - A new start in IDLE at cycle 34 gives h addr 0 at cycle 35.
- Reset mid-run: rst at cycle 12.
  - Cycle 13: all outputs 0, o_busy=0, no o_done.
  - A subsequent start restarts at addr 0.
- DELAY=0, NUM_LANE=4:
  - Per timestep: h 0..3 in cycles 1-4, then c {0,1,2,3} at cycle 5.
  - Done at cycle 11.

Source files
------------

// File: rtl/addr_gen_hc_multi_if.sv
// Handshake and address bus between the H/C read-address generator and its consumer.
// Both sides advance on i_en; the generator reports each run's progress on busy/done.
interface addr_gen_hc_multi_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_LANE   = 2
);
    logic                           i_en;
    logic                           i_start;
    logic                           i_dir;
    logic                           o_busy;
    logic                           o_done;
    logic                           o_valid_h;
    logic [ADDR_WIDTH-1:0]          o_addr_h;
    logic                           o_valid_c;
    logic [NUM_LANE*ADDR_WIDTH-1:0] o_addr_c;

    modport master (
        output i_en, i_start, i_dir,
        input  o_busy, o_done, o_valid_h, o_addr_h, o_valid_c, o_addr_c
    );

    modport slave (
        input  i_en, i_start, i_dir,
        output o_busy, o_done, o_valid_h, o_addr_h, o_valid_c, o_addr_c
    );
endinterface

// File: rtl/addr_gen_hc_multi.sv
// Read-address generator for the LSTM H and C state memories.
// Every timestep and cell group: stream the h addresses, wait for the MAC pipeline, then read the c lanes.
//
// state      | meaning
// S_IDLE     | waiting for i_start
// S_STREAM_H | issuing h address t*NUM_CELL + k
// S_WAIT     | idle DELAY cycles while the MAC pipeline drains
// S_READ_C   | one cycle of NUM_LANE parallel c addresses
// S_DONE     | one-cycle completion pulse
module addr_gen_hc_multi #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 8,
    parameter int NUM_LANE   = 2,
    parameter int DELAY      = 48
) (
    input logic                clk,
    input logic                rst,
    addr_gen_hc_multi_if.slave bus
);
    localparam int NUM_GRP = NUM_CELL / NUM_LANE;
    localparam int KW = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
    localparam int WW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int GW = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NUM_CELL - 1);
    localparam logic [WW-1:0] W_LAST = WW'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [GW-1:0] G_LAST = GW'(NUM_GRP - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);
    localparam logic [ADDR_WIDTH-1:0] NC_A = ADDR_WIDTH'(NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] NL_A = ADDR_WIDTH'(NUM_LANE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM_H,
        S_WAIT,
        S_READ_C,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [WW-1:0] w, w_nxt;
    logic [GW-1:0] g, g_nxt;
    logic [TW-1:0] t, t_nxt;
    logic          dir, dir_nxt;
    logic [TW-1:0] t_last;

    logic                           busy, busy_nxt;
    logic                           done, done_nxt;
    logic                           valid_h, valid_h_nxt;
    logic                           valid_c, valid_c_nxt;
    logic [ADDR_WIDTH-1:0]          addr_h, addr_h_nxt;
    logic [ADDR_WIDTH-1:0]          base_nxt;
    logic [NUM_LANE*ADDR_WIDTH-1:0] addr_c, addr_c_nxt;

    assign t_last = dir ? '0 : T_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            k       <= '0;
            w       <= '0;
            g       <= '0;
            t       <= '0;
            dir     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid_h <= 1'b0;
            valid_c <= 1'b0;
            addr_h  <= '0;
            addr_c  <= '0;
        end else if (bus.i_en) begin
            state   <= state_nxt;
            k       <= k_nxt;
            w       <= w_nxt;
            g       <= g_nxt;
            t       <= t_nxt;
            dir     <= dir_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            valid_h <= valid_h_nxt;
            valid_c <= valid_c_nxt;
            addr_h  <= addr_h_nxt;
            addr_c  <= addr_c_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        w_nxt     = w;
        g_nxt     = g;
        t_nxt     = t;
        dir_nxt   = dir;

        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    dir_nxt   = bus.i_dir;
                    t_nxt     = bus.i_dir ? T_LAST : '0;
                    g_nxt     = '0;
                    k_nxt     = '0;
                    state_nxt = S_STREAM_H;
                end
            end
            S_STREAM_H: begin
                if (k == K_LAST) begin
                    w_nxt     = '0;
                    state_nxt = (DELAY == 0) ? S_READ_C : S_WAIT;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            S_WAIT: begin
                if (w == W_LAST) state_nxt = S_READ_C;
                else             w_nxt     = w + WW'(1);
            end
            S_READ_C: begin
                k_nxt = '0;
                if (g != G_LAST) begin
                    g_nxt     = g + GW'(1);
                    state_nxt = S_STREAM_H;
                end else if (t != t_last) begin
                    g_nxt     = '0;
                    t_nxt     = dir ? t - TW'(1) : t + TW'(1);
                    state_nxt = S_STREAM_H;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are derived from the next-cycle counters so they register alongside the state.
        base_nxt    = ADDR_WIDTH'(t_nxt) * NC_A;
        valid_h_nxt = (state_nxt == S_STREAM_H);
        valid_c_nxt = (state_nxt == S_READ_C);
        done_nxt    = (state_nxt == S_DONE);
        busy_nxt    = (state_nxt != S_IDLE);
        addr_h_nxt  = valid_h_nxt ? base_nxt + ADDR_WIDTH'(k_nxt) : addr_h;
        addr_c_nxt  = addr_c;
        if (valid_c_nxt) begin
            for (int l = 0; l < NUM_LANE; l++) begin
                addr_c_nxt[l*ADDR_WIDTH +: ADDR_WIDTH] =
                    base_nxt + ADDR_WIDTH'(g_nxt) * NL_A + ADDR_WIDTH'(l);
            end
        end
    end

    assign bus.o_busy    = busy;
    assign bus.o_done    = done;
    assign bus.o_valid_h = valid_h;
    assign bus.o_addr_h  = addr_h;
    assign bus.o_valid_c = valid_c;
    assign bus.o_addr_c  = addr_c;
endmodule

// File: tb/tb_addr_gen_hc_multi.sv
// Bench for addr_gen_hc_multi: expected h/c/done events are queued at start time and
// popped by a negedge monitor whenever either generator presents a consumed output.
module tb_addr_gen_hc_multi;
    localparam int AW  = 12;
    localparam int BIG = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addr_gen_hc_multi_if #(.ADDR_WIDTH(AW), .NUM_LANE(2)) bus_a ();
    addr_gen_hc_multi_if #(.ADDR_WIDTH(AW), .NUM_LANE(4)) bus_b ();

    addr_gen_hc_multi #(.ADDR_WIDTH(AW), .TIMESTEP(2), .NUM_CELL(4), .NUM_LANE(2), .DELAY(3))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    addr_gen_hc_multi #(.ADDR_WIDTH(AW), .TIMESTEP(2), .NUM_CELL(4), .NUM_LANE(4), .DELAY(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    typedef struct {
        int          dut;
        int          kind;   // 0 = h, 1 = c, 2 = done
        logic [47:0] addr;
        int          stamp;
    } exp_t;

    exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    task automatic observe(input int dut, input int kind, input logic [47:0] addr);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected: dut%0d kind %0d addr %0h at edge %0d, expected nothing",
                     dut, kind, addr, edge_cnt);
            return;
        end
        e = sb_q.pop_front();
        chk("sb_dut", 64'(dut), 64'(e.dut));
        chk("sb_kind", 64'(kind), 64'(e.kind));
        chk("sb_addr", {16'b0, addr}, {16'b0, e.addr});
        chk("sb_cycle", 64'(edge_cnt), 64'(e.stamp));
    endtask

    always @(negedge clk) begin
        if (bus_a.i_en) begin
            if (bus_a.o_valid_h) observe(0, 0, {36'b0, bus_a.o_addr_h});
            if (bus_a.o_valid_c) observe(0, 1, {24'b0, bus_a.o_addr_c});
            if (bus_a.o_done)    observe(0, 2, 48'b0);
        end
        if (bus_b.i_en) begin
            if (bus_b.o_valid_h) observe(1, 0, {36'b0, bus_b.o_addr_h});
            if (bus_b.o_valid_c) observe(1, 1, bus_b.o_addr_c);
            if (bus_b.o_done)    observe(1, 2, 48'b0);
        end
    end

    task automatic sched(input int dut, input int kind, input logic [47:0] addr, input int cyc,
                         input int s, input int stall_at, input int stall_len, input int limit);
        exp_t e;
        if (cyc <= limit) begin
            e.dut   = dut;
            e.kind  = kind;
            e.addr  = addr;
            e.stamp = s + cyc + ((cyc >= stall_at) ? stall_len : 0);
            sb_q.push_back(e);
        end
    endtask

    // Expected schedule for TIMESTEP=2, NUM_CELL=4; cycle n is the n-th cycle after the start edge.
    task automatic push_run(input int dut, input int nl, input int d, input int s, input bit dirv,
                            input int stall_at, input int stall_len, input int limit);
        int cyc = 1;
        int tt;
        logic [47:0] a;
        for (int ti = 0; ti < 2; ti++) begin
            tt = dirv ? 1 - ti : ti;
            for (int g = 0; g < 4 / nl; g++) begin
                for (int k = 0; k < 4; k++) begin
                    sched(dut, 0, 48'(tt * 4 + k), cyc, s, stall_at, stall_len, limit);
                    cyc++;
                end
                cyc += d;
                a = '0;
                for (int l = 0; l < nl; l++) a[l*12 +: 12] = 12'(tt * 4 + g * nl + l);
                sched(dut, 1, a, cyc, s, stall_at, stall_len, limit);
                cyc++;
            end
        end
        sched(dut, 2, 48'b0, cyc, s, stall_at, stall_len, limit);
    endtask

    task automatic start_run(input int dut, input bit dirv, input int stall_at, input int stall_len,
                             input int limit, output int s);
        if (dut == 0) begin
            bus_a.i_dir   = dirv;
            bus_a.i_start = 1'b1;
        end else begin
            bus_b.i_dir   = dirv;
            bus_b.i_start = 1'b1;
        end
        s = edge_cnt;
        push_run(dut, (dut == 0) ? 2 : 4, (dut == 0) ? 3 : 0, s, dirv, stall_at, stall_len, limit);
        @(posedge clk);
        #2;
        bus_a.i_start = 1'b0;
        bus_b.i_start = 1'b0;
    endtask

    task automatic goto_cycle(input int s, input int c);
        while (edge_cnt < s + c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        repeat (3) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int s2;
        rst = 1'b1;
        bus_a.i_en = 1'b1; bus_a.i_start = 1'b0; bus_a.i_dir = 1'b0;
        bus_b.i_en = 1'b1; bus_b.i_start = 1'b0; bus_b.i_dir = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid_h", 64'(bus_a.o_valid_h), 64'd0);
        chk("rst_addr_h",  64'(bus_a.o_addr_h),  64'd0);
        chk("rst_valid_c", 64'(bus_a.o_valid_c), 64'd0);
        chk("rst_addr_c",  64'(bus_a.o_addr_c),  64'd0);
        chk("rst_busy",    64'(bus_a.o_busy),    64'd0);
        chk("rst_done",    64'(bus_a.o_done),    64'd0);
        chk("rst_b_busy",  64'(bus_b.o_busy),    64'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Forward run
        start_run(0, 1'b0, BIG, 0, BIG, s);
        chk("fwd_busy_c1", 64'(bus_a.o_busy), 64'd1);
        chk("fwd_addr_c1", 64'(bus_a.o_addr_h), 64'd0);
        goto_cycle(s, 8);
        chk("fwd_c_c8", 64'(bus_a.o_addr_c), 64'h001000);
        goto_cycle(s, 33);
        chk("fwd_done_c33", 64'(bus_a.o_done), 64'd1);
        chk("fwd_busy_c33", 64'(bus_a.o_busy), 64'd1);
        goto_cycle(s, 34);
        chk("fwd_busy_c34", 64'(bus_a.o_busy), 64'd0);
        drain(50);

        // Backward run
        start_run(0, 1'b1, BIG, 0, BIG, s);
        chk("bwd_addr_c1", 64'(bus_a.o_addr_h), 64'd4);
        goto_cycle(s, 8);
        chk("bwd_c_c8", 64'(bus_a.o_addr_c), 64'h005004);
        goto_cycle(s, 32);
        chk("bwd_c_c32", 64'(bus_a.o_addr_c), 64'h003002);
        drain(50);

        // Stall with i_en low for cycles 3-5
        start_run(0, 1'b0, 3, 3, BIG, s);
        goto_cycle(s, 3);
        bus_a.i_en = 1'b0;
        goto_cycle(s, 5);
        chk("stall_addr_h", 64'(bus_a.o_addr_h), 64'd2);
        chk("stall_valid_h", 64'(bus_a.o_valid_h), 64'd1);
        goto_cycle(s, 6);
        bus_a.i_en = 1'b1;
        goto_cycle(s, 36);
        chk("stall_done_c36", 64'(bus_a.o_done), 64'd1);
        drain(50);

        // Start while busy and in DONE is ignored
        start_run(0, 1'b0, BIG, 0, BIG, s);
        goto_cycle(s, 10);
        bus_a.i_start = 1'b1;
        goto_cycle(s, 11);
        bus_a.i_start = 1'b0;
        goto_cycle(s, 33);
        bus_a.i_start = 1'b1;
        goto_cycle(s, 34);
        chk("ign_busy_c34", 64'(bus_a.o_busy), 64'd0);
        start_run(0, 1'b0, BIG, 0, BIG, s2);
        chk("restart_addr_h", 64'(bus_a.o_addr_h), 64'd0);
        chk("restart_valid_h", 64'(bus_a.o_valid_h), 64'd1);
        drain(50);

        // Reset mid-run
        start_run(0, 1'b0, BIG, 0, 12, s);
        goto_cycle(s, 12);
        rst = 1'b1;
        goto_cycle(s, 13);
        chk("mrst_valid_h", 64'(bus_a.o_valid_h), 64'd0);
        chk("mrst_addr_h",  64'(bus_a.o_addr_h),  64'd0);
        chk("mrst_valid_c", 64'(bus_a.o_valid_c), 64'd0);
        chk("mrst_addr_c",  64'(bus_a.o_addr_c),  64'd0);
        chk("mrst_busy",    64'(bus_a.o_busy),    64'd0);
        chk("mrst_done",    64'(bus_a.o_done),    64'd0);
        rst = 1'b0;
        goto_cycle(s, 40);
        drain(5);
        start_run(0, 1'b0, BIG, 0, BIG, s);
        chk("mrst_restart_addr", 64'(bus_a.o_addr_h), 64'd0);
        drain(50);

        // DELAY=0, NUM_LANE=4
        start_run(1, 1'b0, BIG, 0, BIG, s);
        goto_cycle(s, 5);
        chk("d0_c_c5", 64'(bus_b.o_addr_c), 64'h003002001000);
        chk("d0_valid_c_c5", 64'(bus_b.o_valid_c), 64'd1);
        goto_cycle(s, 11);
        chk("d0_done_c11", 64'(bus_b.o_done), 64'd1);
        drain(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
